irq_source_ctrl: RTL and testbench

- Producer side of the interrupt path.
- Synchronises 16 external device request lines and runs a programmable interval timer on line 0. It then drives the 16-bit `interrupts` vector that the control register file ORs into ISR (cr2).
- It also watches the masked `interrupt_state` returned by the control register file. From it, it produces a registered interrupt request and vector number for the pipeline's exception logic.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_sync_edge.sv | 31 +++
 rtl/irq_source_ctrl.sv | 100 ++++++++++
 tb/tb_irq_source_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and the lowest-set-bit priority encoder for the interrupt path.
package irq_pkg;

    localparam int IRQ_TIMER         = 0;
    localparam int IMR_GLOBAL_EN_BIT = 31;
    localparam int CR_ISR            = 2;
    localparam int CR_IMR            = 3;

    // Lowest set bit wins; returns 0 when nothing is pending.
    function automatic logic [3:0] prio_enc16(input logic [15:0] pend);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: multi-flop synchroniser plus combinational edge/level detect.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dev_irq,
    input  logic edge_mode,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dev_irq};
            prev_q <= s;
        end
    end

    // Mode is applied combinationally so a change acts on the very next register update.
    assign req = edge_mode ? (s & ~prev_q) : s;

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt producer: synchronised device lines, interval timer on line 0,
// and the registered request/vector presented to the pipeline.
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [NUM_IRQ-1:0] dev_irq,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic               timer_wen,
    input  logic [TIMER_W-1:0] timer_wdata,
    output logic [NUM_IRQ-1:0] interrupts,
    input  logic [31:0]        interrupt_state,
    input  logic               stall,
    input  logic               irq_taken,
    output logic               irq_req,
    output logic [3:0]         irq_vector,
    output logic [TIMER_W-1:0] timer_count
);

    logic [NUM_IRQ-1:0] dev_req;
    logic [NUM_IRQ-1:0] irq_next;
    logic [TIMER_W-1:0] period_q;
    logic               timer_en_q;
    logic               timer_expire;
    logic [15:0]        pend16;
    logic               unused_state_hi;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk       (clk),
            .rst       (rst),
            .dev_irq   (dev_irq[i]),
            .edge_mode (edge_mode[i]),
            .req       (dev_req[i])
        );
    end

    // A write landing on the expiry cycle takes priority and suppresses the pulse.
    assign timer_expire = timer_en_q & clk_en & ~timer_wen & (timer_count == TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q    <= '0;
            timer_count <= '0;
            timer_en_q  <= 1'b0;
        end else if (timer_wen) begin
            period_q    <= timer_wdata;
            timer_count <= timer_wdata;
            timer_en_q  <= (timer_wdata != '0);
        end else if (timer_en_q && clk_en) begin
            if (timer_count == TIMER_W'(1))
                timer_count <= period_q;
            else
                timer_count <= timer_count - TIMER_W'(1);
        end
    end

    always_comb begin
        irq_next            = dev_req;
        irq_next[IRQ_TIMER] = dev_req[IRQ_TIMER] | timer_expire;
    end

    always_ff @(posedge clk) begin
        if (rst)
            interrupts <= '0;
        else
            interrupts <= irq_next;
    end

    always_comb begin
        pend16              = '0;
        pend16[NUM_IRQ-1:0] = interrupt_state[NUM_IRQ-1:0];
    end

    assign unused_state_hi = ^interrupt_state[31:NUM_IRQ];

    // irq_taken clears the request even under stall, so a masked-off IMR cannot be re-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_req    <= 1'b0;
            irq_vector <= 4'd0;
        end else begin
            if (!stall)
                irq_vector <= prio_enc16(pend16);
            if (irq_taken)
                irq_req <= 1'b0;
            else if (!stall)
                irq_req <= |pend16;
        end
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: sync latency, edge/level, timer, priority, stall, taken, reset.
module tb_irq_source_ctrl;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [15:0] dev_irq;
    logic [15:0] edge_mode;
    logic        timer_wen;
    logic [31:0] timer_wdata;
    logic [15:0] interrupts;
    logic [31:0] interrupt_state;
    logic        stall;
    logic        irq_taken;
    logic        irq_req;
    logic [3:0]  irq_vector;
    logic [31:0] timer_count;

    int checks = 0;
    int errors = 0;

    irq_source_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .dev_irq         (dev_irq),
        .edge_mode       (edge_mode),
        .timer_wen       (timer_wen),
        .timer_wdata     (timer_wdata),
        .interrupts      (interrupts),
        .interrupt_state (interrupt_state),
        .stall           (stall),
        .irq_taken       (irq_taken),
        .irq_req         (irq_req),
        .irq_vector      (irq_vector),
        .timer_count     (timer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (interrupts !== 16'h0 || irq_req !== 1'b0 || irq_vector !== 4'd0 || timer_count !== 32'd0) begin
            errors++;
            $display("FAIL reset: irq=%h req=%b vec=%0d cnt=%0d, want all 0", interrupts, irq_req, irq_vector, timer_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_edge();
        logic [15:0] exp;
        edge_mode[5] = 1'b1;
        dev_irq[5]   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k == 3) ? 16'h0020 : 16'h0000;
            checks++;
            if (interrupts !== exp) begin
                errors++;
                $display("FAIL edge5 cycle %0d: got %h want %h", k, interrupts, exp);
            end
        end
        dev_irq[5] = 1'b0;
        repeat (4) tick();
        edge_mode[5] = 1'b0;
    endtask

    task automatic test_level();
        logic [15:0] exp;
        edge_mode[3] = 1'b0;
        dev_irq[3]   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 10) dev_irq[3] = 1'b0;
            exp = (k >= 3 && k <= 12) ? 16'h0008 : 16'h0000;
            checks++;
            if (interrupts !== exp) begin
                errors++;
                $display("FAIL level3 cycle %0d: got %h want %h", k, interrupts, exp);
            end
        end
    endtask

    task automatic test_mode_switch();
        // Line 7 held high as level, then switched to edge: no pulse since s and p are both 1.
        dev_irq[7] = 1'b1;
        repeat (5) tick();
        edge_mode[7] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (interrupts !== 16'h0000) begin
                errors++;
                $display("FAIL mode_switch cycle %0d: got %h want 0000", k, interrupts);
            end
        end
        dev_irq[7]   = 1'b0;
        edge_mode[7] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_timer();
        logic [31:0] exp_cnt;
        logic        exp_p;
        clk_en      = 1'b1;
        timer_wen   = 1'b1;
        timer_wdata = 32'd4;
        tick();
        timer_wen = 1'b0;
        checks++;
        if (timer_count !== 32'd4 || interrupts[0] !== 1'b0) begin
            errors++;
            $display("FAIL timer_load: cnt=%0d irq0=%b want 4/0", timer_count, interrupts[0]);
        end
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_cnt = 32'(4 - (k % 4));
            exp_p   = (k % 4 == 0);
            checks++;
            if (timer_count !== exp_cnt || interrupts[0] !== exp_p) begin
                errors++;
                $display("FAIL timer_run %0d: cnt=%0d irq0=%b want %0d/%b", k, timer_count, interrupts[0], exp_cnt, exp_p);
            end
        end
        clk_en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (timer_count !== 32'd1 || interrupts[0] !== 1'b0) begin
                errors++;
                $display("FAIL timer_freeze %0d: cnt=%0d irq0=%b want 1/0", k, timer_count, interrupts[0]);
            end
        end
        clk_en = 1'b1;
        tick();
        checks++;
        if (timer_count !== 32'd4 || interrupts[0] !== 1'b1) begin
            errors++;
            $display("FAIL timer_resume: cnt=%0d irq0=%b want 4/1", timer_count, interrupts[0]);
        end
        timer_wen   = 1'b1;
        timer_wdata = 32'd0;
        tick();
        timer_wen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (timer_count !== 32'd0 || interrupts[0] !== 1'b0) begin
                errors++;
                $display("FAIL timer_off %0d: cnt=%0d irq0=%b want 0/0", k, timer_count, interrupts[0]);
            end
        end
    endtask

    task automatic test_write_on_expiry();
        logic [31:0] exp_cnt;
        logic        exp_p;
        timer_wen   = 1'b1;
        timer_wdata = 32'd3;
        tick();
        timer_wen = 1'b0;
        tick();
        tick();
        checks++;
        if (timer_count !== 32'd1) begin
            errors++;
            $display("FAIL expiry_setup: cnt=%0d want 1", timer_count);
        end
        timer_wen   = 1'b1;
        timer_wdata = 32'd7;
        tick();
        timer_wen = 1'b0;
        checks++;
        if (timer_count !== 32'd7 || interrupts[0] !== 1'b0) begin
            errors++;
            $display("FAIL expiry_write: cnt=%0d irq0=%b want 7/0", timer_count, interrupts[0]);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_cnt = (k == 7) ? 32'd7 : 32'(7 - k);
            exp_p   = (k == 7);
            checks++;
            if (timer_count !== exp_cnt || interrupts[0] !== exp_p) begin
                errors++;
                $display("FAIL expiry_after %0d: cnt=%0d irq0=%b want %0d/%b", k, timer_count, interrupts[0], exp_cnt, exp_p);
            end
        end
        timer_wen   = 1'b1;
        timer_wdata = 32'd0;
        tick();
        timer_wen = 1'b0;
        tick();
    endtask

    task automatic test_priority_stall();
        interrupt_state = 32'h8000_0048;
        tick();
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 4'd3) begin
            errors++;
            $display("FAIL prio: req=%b vec=%0d want 1/3", irq_req, irq_vector);
        end
        stall           = 1'b1;
        interrupt_state = 32'h0000_0001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (irq_req !== 1'b1 || irq_vector !== 4'd3) begin
                errors++;
                $display("FAIL stall_hold %0d: req=%b vec=%0d want 1/3", k, irq_req, irq_vector);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 4'd0) begin
            errors++;
            $display("FAIL stall_release: req=%b vec=%0d want 1/0", irq_req, irq_vector);
        end
        interrupt_state = 32'h0000_8000;
        tick();
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 4'd15) begin
            errors++;
            $display("FAIL prio15: req=%b vec=%0d want 1/15", irq_req, irq_vector);
        end
        interrupt_state = 32'hFFFF_0000;
        tick();
        checks++;
        if (irq_req !== 1'b0 || irq_vector !== 4'd0) begin
            errors++;
            $display("FAIL hi_ignored: req=%b vec=%0d want 0/0", irq_req, irq_vector);
        end
    endtask

    task automatic test_taken();
        interrupt_state = 32'h0000_0004;
        tick();
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 4'd2) begin
            errors++;
            $display("FAIL taken_pre: req=%b vec=%0d want 1/2", irq_req, irq_vector);
        end
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL taken_clear: req=%b want 0", irq_req);
        end
        tick();
        checks++;
        if (irq_req !== 1'b1) begin
            errors++;
            $display("FAIL taken_reassert: req=%b want 1", irq_req);
        end
        stall     = 1'b1;
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        checks++;
        if (irq_req !== 1'b0 || irq_vector !== 4'd2) begin
            errors++;
            $display("FAIL taken_stall: req=%b vec=%0d want 0/2", irq_req, irq_vector);
        end
        tick();
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL taken_stall_hold: req=%b want 0", irq_req);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (irq_req !== 1'b1) begin
            errors++;
            $display("FAIL taken_unstall: req=%b want 1", irq_req);
        end
    endtask

    task automatic test_reset_mid();
        interrupt_state = 32'h0000_0010;
        dev_irq[3]      = 1'b1;
        timer_wen       = 1'b1;
        timer_wdata     = 32'd5;
        tick();
        timer_wen = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (interrupts !== 16'h0 || irq_req !== 1'b0 || irq_vector !== 4'd0 || timer_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: irq=%h req=%b vec=%0d cnt=%0d want all 0", interrupts, irq_req, irq_vector, timer_count);
        end
        rst             = 1'b0;
        dev_irq         = 16'h0;
        interrupt_state = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (interrupts !== 16'h0 || irq_req !== 1'b0 || timer_count !== 32'd0) begin
                errors++;
                $display("FAIL post_reset %0d: irq=%h req=%b cnt=%0d want 0", k, interrupts, irq_req, timer_count);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        clk_en          = 1'b1;
        dev_irq         = 16'h0;
        edge_mode       = 16'h0;
        timer_wen       = 1'b0;
        timer_wdata     = 32'd0;
        interrupt_state = 32'h0;
        stall           = 1'b0;
        irq_taken       = 1'b0;

        test_reset();
        test_edge();
        test_level();
        test_mode_switch();
        test_timer();
        test_write_on_expiry();
        test_priority_stall();
        test_taken();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
